// File: rtl/axis_hdr_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header inserter.
// Lane vectors are carried at MAX_BYTES width; callers size-cast down to their beat width.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    localparam int MAX_BYTES = 64;
    typedef logic [MAX_BYTES-1:0] lane_vec_t;

    function automatic logic [7:0] popcount(input lane_vec_t v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < MAX_BYTES; i++) c = c + 8'(v[i]);
        return c;
    endfunction

    // n ones packed against bit w-1 of a w-lane vector (byte 0 sits at the top lane)
    function automatic lane_vec_t msb_mask(input logic [7:0] n, input logic [7:0] w);
        lane_vec_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if ((i < int'(w)) && (i + int'(n) >= int'(w))) m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Concatenates rcnt residual bytes with n payload bytes, MSB-first, across a 2-beat window.
// hi is the next output beat; lo is whatever spills past it, already MSB-aligned.
module axis_byte_merge
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD     = 32,
    parameter int BYTE_CNT_WD = $clog2(DATA_WD / 8)
) (
    input  logic [DATA_WD-1:0]     res,
    input  logic [BYTE_CNT_WD:0]   rcnt,
    input  logic [DATA_WD-1:0]     data,
    input  logic [BYTE_CNT_WD:0]   n,
    output logic [DATA_WD-1:0]     hi,
    output logic [DATA_WD-1:0]     lo,
    output logic [BYTE_CNT_WD+1:0] tot
);
    localparam int W = DATA_WD / 8;

    logic [W-1:0]           lane_en;
    logic [DATA_WD-1:0]     data_m;
    logic [2*DATA_WD-1:0]   cat;
    logic [BYTE_CNT_WD+3:0] shamt;

    assign lane_en = W'(msb_mask(8'(n), 8'(W)));

    // Unused payload lanes are zeroed so they never leak into the residual
    for (genvar b = 0; b < W; b++) begin : g_lane
        assign data_m[8*b +: 8] = data[8*b +: 8] & {8{lane_en[b]}};
    end

    assign shamt = {rcnt, 3'b000};
    assign cat   = {res, {DATA_WD{1'b0}}} | ({data_m, {DATA_WD{1'b0}}} >> shamt);
    assign hi    = cat[2*DATA_WD-1 -: DATA_WD];
    assign lo    = cat[DATA_WD-1:0];
    assign tot   = {1'b0, rcnt} + {1'b0, n};

endmodule

// File: rtl/axis_header_inserter_pipe.sv
// Prepends a 0..W byte header to each AXI-Stream packet at one beat per clock,
// with registered output, downstream backpressure and a flush beat when the tail overflows.
module axis_header_inserter_pipe
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD:0]    byte_insert_cnt,
    output logic                    ready_insert,
    output logic                    keep_err
);
    localparam int CW = BYTE_CNT_WD + 1;
    localparam int TW = BYTE_CNT_WD + 2;
    localparam logic [CW-1:0] W_C = CW'(DATA_BYTE_WD);
    localparam logic [TW-1:0] W_T = TW'(DATA_BYTE_WD);

    typedef struct packed {
        logic [DATA_WD-1:0]      data;
        logic [DATA_BYTE_WD-1:0] keep;
        logic                    last;
    } beat_t;

    state_e state_q, state_d;

    logic [DATA_WD-1:0]      res_q;
    logic [CW-1:0]           rcnt_q;
    beat_t                   out_q;
    logic                    out_vld_q;
    logic                    keep_err_q;

    logic                    out_free, hdr_fire, in_fire, flush_go;
    logic [7:0]              pc_in;
    logic [CW-1:0]           n_beat, cnt_c;
    logic                    keep_in_bad, hdr_bad, spill;
    logic [DATA_WD-1:0]      hdr_sh, mrg_hi, mrg_lo;
    logic [TW-1:0]           tot;
    logic [DATA_BYTE_WD-1:0] keep_tot, keep_res;

    assign out_free = !out_vld_q || ready_out;
    assign hdr_fire = valid_insert && ready_insert;
    assign in_fire  = valid_in && ready_in;

    // Input sanitising: bad keeps are flagged but the beat still proceeds
    always_comb begin
        pc_in       = popcount(lane_vec_t'(keep_in));
        keep_in_bad = last_in ? ((pc_in == 8'd0) ||
                                 (lane_vec_t'(keep_in) != msb_mask(pc_in, 8'(DATA_BYTE_WD))))
                              : (keep_in != '1);
        n_beat      = last_in ? CW'(pc_in) : W_C;
        cnt_c       = (byte_insert_cnt > W_C) ? W_C : byte_insert_cnt;
        hdr_bad     = (byte_insert_cnt > W_C) ||
                      (popcount(lane_vec_t'(keep_insert)) != 8'(byte_insert_cnt));
        hdr_sh      = data_insert << {W_C - cnt_c, 3'b000};
    end

    axis_byte_merge #(
        .DATA_WD     (DATA_WD),
        .BYTE_CNT_WD (BYTE_CNT_WD)
    ) u_merge (
        .res  (res_q),
        .rcnt (rcnt_q),
        .data (data_in),
        .n    (n_beat),
        .hi   (mrg_hi),
        .lo   (mrg_lo),
        .tot  (tot)
    );

    always_comb begin
        spill    = tot > W_T;
        keep_tot = DATA_BYTE_WD'(msb_mask(8'(tot), 8'(DATA_BYTE_WD)));
        keep_res = DATA_BYTE_WD'(msb_mask(8'(rcnt_q), 8'(DATA_BYTE_WD)));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hdr_fire) state_d = STREAM;
            STREAM:  if (in_fire && last_in) state_d = spill ? FLUSH : IDLE;
            FLUSH:   if (out_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshakes are held off while reset is asserted so nothing is accepted then dropped
    always_comb begin
        ready_insert = (state_q == IDLE) && !rst;
        ready_in     = (state_q == STREAM) && out_free && !rst;
        flush_go     = (state_q == FLUSH) && out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            rcnt_q     <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            keep_err_q <= 1'b0;
        end else begin
            keep_err_q <= (hdr_fire && hdr_bad) || (in_fire && keep_in_bad);
            if (hdr_fire) begin
                res_q  <= hdr_sh;
                rcnt_q <= cnt_c;
            end
            if (in_fire) begin
                out_vld_q  <= 1'b1;
                out_q.data <= mrg_hi;
                if (last_in && !spill) begin
                    out_q.keep <= keep_tot;
                    out_q.last <= 1'b1;
                end else begin
                    // full beat out; spill-over waits in the residual (rcnt is unchanged mid-packet)
                    out_q.keep <= '1;
                    out_q.last <= 1'b0;
                    res_q      <= mrg_lo;
                    if (last_in) rcnt_q <= CW'(tot - W_T);
                end
            end else if (flush_go) begin
                out_vld_q  <= 1'b1;
                out_q.data <= res_q;
                out_q.keep <= keep_res;
                out_q.last <= 1'b1;
            end else if (ready_out) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign valid_out = out_vld_q;
    assign data_out  = out_q.data;
    assign keep_out  = out_q.keep;
    assign last_out  = out_q.last;
    assign keep_err  = keep_err_q;

endmodule

// File: tb/tb_axis_header_inserter_pipe.sv
// Self-checking bench: packets are modelled as byte streams (header ++ payload) re-chunked into beats.
module tb_axis_header_inserter_pipe;
    localparam int DW = 32;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [W-1:0]  keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic          valid_insert = 1'b0;
    logic [DW-1:0] data_insert = '0;
    logic [W-1:0]  keep_insert = '0;
    logic [2:0]    byte_insert_cnt = '0;
    logic          ready_insert;
    logic          keep_err;

    always #5 clk = ~clk;

    axis_header_inserter_pipe #(.DATA_WD(DW)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
        .keep_err(keep_err)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t mdl_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    err_seen = 0;
    int    rmode = 0;
    bit    stall_req = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ones_msb(input int n);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (i >= 4 - n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Byte-stream model: header bytes (LSB side, clamped to W) then payload bytes, chunked MSB-first
    function automatic void model_pkt(input logic [31:0] hdr, input int cnt, input int nb,
                                      input logic [31:0] pl[8], input logic [3:0] kk[8]);
        byte unsigned bq[$];
        int c, n;
        beat_t bt;
        mdl_q.delete();
        c = (cnt > 4) ? 4 : cnt;
        for (int i = 0; i < c; i++) bq.push_back(hdr[8*(c-1-i) +: 8]);
        for (int b = 0; b < nb; b++) begin
            n = (b == nb - 1) ? $countones(kk[b]) : 4;
            for (int j = 0; j < n; j++) bq.push_back(pl[b][31-8*j -: 8]);
        end
        while (bq.size() > 0) begin
            bt.d = '0;
            n = 0;
            while (n < 4 && bq.size() > 0) begin
                bt.d[31-8*n -: 8] = bq.pop_front();
                n++;
            end
            bt.k = ones_msb(n);
            bt.l = (bq.size() == 0);
            mdl_q.push_back(bt);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        if (rmode == 1) ready_out = ($urandom_range(0, 3) != 0);
        else            ready_out = !stall_req;
    end

    // Per-cycle compare against the model queue, hold rule and error-pulse rule
    initial begin
        logic  stall_prev, pend;
        beat_t snap, e;
        logic [31:0] m;
        stall_prev = 1'b0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                pend = 1'b0;
            end else begin
                chk("keep_err", 64'(keep_err), 64'(pend));
                if (keep_err) err_seen++;
                if (stall_prev)
                    chk("hold", 64'({valid_out, data_out, keep_out, last_out}),
                        64'({1'b1, snap.d, snap.k, snap.l}));
                if (valid_out && ready_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_beat: got %h expected no beat", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        m = kmask(e.k);
                        chk("beat", 64'({data_out & m, keep_out, last_out}), 64'({e.d & m, e.k, e.l}));
                    end
                end
                pend = (valid_insert && ready_insert &&
                        (byte_insert_cnt > 3'd4 || $countones(keep_insert) != int'(byte_insert_cnt))) ||
                       (valid_in && ready_in &&
                        (last_in ? !(keep_in inside {4'h8, 4'hC, 4'hE, 4'hF}) : (keep_in != 4'hF)));
                stall_prev = valid_out && !ready_out;
                snap.d = data_out;
                snap.k = keep_out;
                snap.l = last_out;
            end
        end
    end

    task automatic idle_bubble(input bit bubbles);
        if (bubbles && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [31:0] d, input logic [2:0] cnt, input logic [3:0] k);
        int t;
        valid_insert = 1'b1; data_insert = d; byte_insert_cnt = cnt; keep_insert = k;
        t = 0;
        @(negedge clk);
        while (!ready_insert && t < 200) begin @(negedge clk); t++; end
        if (!ready_insert) begin
            n_cmp++; n_bad++;
            $display("FAIL hdr_timeout: ready_insert 0 expected 1");
        end
        @(posedge clk);
        #1 valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < 200) begin @(negedge clk); t++; end
        if (!ready_in) begin
            n_cmp++; n_bad++;
            $display("FAIL beat_timeout: ready_in 0 expected 1");
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        chk("beat_latency", 64'(valid_out), 64'd1);
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input logic [2:0] cnt, input logic [3:0] kins,
                            input int nb, input logic [31:0] pl[8], input logic [3:0] kk[8],
                            input int rst_at, input bit bubbles);
        model_pkt(hdr, int'(cnt), nb, pl, kk);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        idle_bubble(bubbles);
        send_hdr(hdr, cnt, kins);
        for (int b = 0; b < nb; b++) begin
            if (b == rst_at) begin
                valid_in = 1'b1; data_in = pl[b]; keep_in = kk[b]; last_in = (b == nb - 1);
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                chk("midrst_outs", 64'({valid_out, last_out, keep_out, data_out, keep_err}), 64'd0);
                chk("midrst_ready", 64'({ready_in, ready_insert}), 64'd0);
                rst = 1'b0;
                valid_in = 1'b0;
                return;
            end
            idle_bubble(bubbles);
            send_beat(pl[b], kk[b], b == nb - 1);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || valid_out) && t < 500) begin @(negedge clk); t++; end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pl[8];
        logic [3:0]  kk[8];
        int e0, nb, t;
        logic [2:0] cnt;
        logic [3:0] kins;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 64'({valid_out, last_out, keep_out, data_out, keep_err}), 64'd0);
        chk("reset_ready", 64'({ready_in, ready_insert}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_insert_after_rst", 64'({ready_insert, ready_in}), 64'b10);
        @(posedge clk);
        #1;

        // header CCDD + 11223344, 5566 (keep 1100 last)
        pl[0] = 32'h11223344; kk[0] = 4'hF;
        pl[1] = 32'h55667788; kk[1] = 4'hC;
        model_pkt(32'hAABBCCDD, 2, 2, pl, kk);
        chk("pin1_n", 64'(mdl_q.size()), 64'd2);
        chk("pin1_b0", 64'({mdl_q[0].d, mdl_q[0].k, mdl_q[0].l}), 64'({32'hCCDD1122, 4'hF, 1'b0}));
        chk("pin1_b1", 64'({mdl_q[1].d, mdl_q[1].k, mdl_q[1].l}), 64'({32'h33445566, 4'hF, 1'b1}));
        send_pkt(32'hAABBCCDD, 3'd2, 4'b0011, 2, pl, kk, -1, 1'b0);
        drain();

        // 3-byte header overflows the last beat -> flush beat
        pl[0] = 32'h11223344; kk[0] = 4'hF;
        model_pkt(32'hAABBCCDD, 3, 1, pl, kk);
        chk("pin2_b0", 64'({mdl_q[0].d, mdl_q[0].k, mdl_q[0].l}), 64'({32'hBBCCDD11, 4'hF, 1'b0}));
        chk("pin2_b1", 64'({mdl_q[1].d & 32'hFFFFFF00, mdl_q[1].k, mdl_q[1].l}),
            64'({32'h22334400, 4'hE, 1'b1}));
        send_pkt(32'hAABBCCDD, 3'd3, 4'b0111, 1, pl, kk, -1, 1'b0);
        drain();

        // zero-byte header: passthrough with 1-clk latency
        pl[0] = 32'hDEADBEEF; kk[0] = 4'hF;
        pl[1] = 32'h01234567; kk[1] = 4'hF;
        pl[2] = 32'h89ABCDEF; kk[2] = 4'h8;
        model_pkt(32'h0, 0, 3, pl, kk);
        chk("pin3_b2", 64'({mdl_q[2].d & 32'hFF000000, mdl_q[2].k, mdl_q[2].l}),
            64'({32'h89000000, 4'h8, 1'b1}));
        send_pkt(32'h0, 3'd0, 4'b0000, 3, pl, kk, -1, 1'b0);
        chk("pass_last", 64'({valid_out, last_out, keep_out, data_out[31:24]}),
            64'({1'b1, 1'b1, 4'h8, 8'h89}));
        drain();

        // downstream stall for 3 clocks mid-packet
        for (int i = 0; i < 4; i++) begin pl[i] = $urandom; kk[i] = 4'hF; end
        kk[3] = 4'hE;
        fork
            send_pkt(32'h0A0B0C0D, 3'd2, 4'b0011, 4, pl, kk, -1, 1'b0);
            begin
                t = 0;
                while (!valid_out && t < 100) begin @(negedge clk); t++; end
                @(posedge clk);
                #1 stall_req = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready_in", 64'({ready_in, valid_out}), 64'b01);
                end
                @(posedge clk);
                #1 stall_req = 1'b0;
            end
        join
        drain();

        // reset while beat 2 is presented; the packet is dropped
        for (int i = 0; i < 4; i++) begin pl[i] = $urandom; kk[i] = 4'hF; end
        send_pkt(32'h12345678, 3'd1, 4'b0001, 4, pl, kk, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", 64'({valid_out, ready_insert}), 64'b01);
        @(posedge clk);
        #1;
        pl[0] = 32'h11223344; kk[0] = 4'hF;
        pl[1] = 32'h55667788; kk[1] = 4'hC;
        send_pkt(32'hAABBCCDD, 3'd2, 4'b0011, 2, pl, kk, -1, 1'b0);
        drain();

        // keep_insert disagrees with count: one error pulse, count wins
        e0 = err_seen;
        send_pkt(32'hAABBCCDD, 3'd2, 4'b0001, 2, pl, kk, -1, 1'b0);
        drain();
        chk("err_pulse_count", 64'(err_seen - e0), 64'd1);

        // count above W is clamped
        e0 = err_seen;
        send_pkt(32'hA1B2C3D4, 3'd6, 4'b1111, 2, pl, kk, -1, 1'b0);
        drain();
        chk("clamp_err_count", 64'(err_seen - e0), 64'd1);

        rmode = 1;
        for (int p = 0; p < 150; p++) begin
            cnt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            kins = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ones_msb(0) | (4'hF >> (4 - ((cnt > 4) ? 4 : cnt)));
            nb   = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                pl[b] = $urandom;
                if (b < nb - 1)
                    kk[b] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 14)) : 4'hF;
                else if ($urandom_range(0, 6) == 0)
                    kk[b] = 4'($urandom_range(1, 15));
                else
                    kk[b] = ones_msb($urandom_range(1, 4));
            end
            send_pkt($urandom, cnt, kins, nb, pl, kk, -1, 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
